// File: rtl/virtual_ds2431_pkg.sv
// Shared constants and state encoding for the virtual DS2431 memory-command handlers.
package virtual_ds2431_pkg;

    localparam logic [7:0] CMD_COPY_SCRATCHPAD = 8'h55;
    localparam logic [7:0] AA_PATTERN          = 8'hAA;
    localparam logic       DIR_RX              = 1'b0;
    localparam logic       DIR_TX              = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_TRIG,
        ST_RX_WAIT,
        ST_CHECK,
        ST_COPY,
        ST_PROG,
        ST_TX_TRIG,
        ST_TX_WAIT,
        ST_DONE,
        ST_FAIL
    } copy_state_t;

    // Authorization byte expected at each position of the TA1/TA2/ES sequence.
    function automatic logic [7:0] auth_byte(
        input logic [1:0] idx,
        input logic [7:0] ta1,
        input logic [7:0] ta2,
        input logic [7:0] es
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = ta1;
            2'd1:    b = ta2;
            default: b = es;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ds2431_done_edge.sv
// Rising-edge detector on the byte-transfer engine's done/idle level.
module ds2431_done_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/virtual_ds2431_mem_copy_scratchpad.sv
// Copy Scratchpad (0x55) handler: receives TA1/TA2/E-S, authorizes against the
// stored values, triggers the copy, waits tPROG and then sends the 0xAA pattern.
module virtual_ds2431_mem_copy_scratchpad
    import virtual_ds2431_pkg::*;
#(
    parameter int PROG_CYCLES = 16,
    parameter int AA_BYTES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] TA1,
    input  logic [7:0] TA2,
    input  logic [7:0] ES,
    input  logic       cmdRunTrig,
    input  logic [7:0] receiveDat,
    output logic       nRxTx,
    output logic       transTrig,
    input  logic       ByteTransDone,
    output logic [7:0] sendDat,
    output logic       copyEn,
    output logic       cmdDone,
    output logic       cmdFailed
);

    localparam int PW = (PROG_CYCLES < 1) ? 1 : $clog2(PROG_CYCLES + 1);
    localparam int TW = (AA_BYTES < 1) ? 1 : $clog2(AA_BYTES + 1);

    copy_state_t   state, state_n;
    logic [1:0]    byte_idx, byte_idx_n;
    logic          mismatch, mismatch_n;
    logic [PW-1:0] prog_cnt, prog_cnt_n;
    logic [TW-1:0] tx_cnt, tx_cnt_n;
    logic [TW-1:0] tx_cnt_inc;
    logic          done_rise;

    logic          nrxtx_n;
    logic          trans_trig_n;
    logic [7:0]    send_dat_n;
    logic          copy_en_n;
    logic          cmd_done_n;
    logic          cmd_failed_n;

    ds2431_done_edge u_done_edge (
        .clk   (clk),
        .rst   (rst),
        .level (ByteTransDone),
        .rise  (done_rise)
    );

    assign tx_cnt_inc = tx_cnt + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_idx  <= '0;
            mismatch  <= 1'b0;
            prog_cnt  <= '0;
            tx_cnt    <= '0;
            nRxTx     <= DIR_RX;
            transTrig <= 1'b0;
            sendDat   <= AA_PATTERN;
            copyEn    <= 1'b0;
            cmdDone   <= 1'b0;
            cmdFailed <= 1'b0;
        end else begin
            state     <= state_n;
            byte_idx  <= byte_idx_n;
            mismatch  <= mismatch_n;
            prog_cnt  <= prog_cnt_n;
            tx_cnt    <= tx_cnt_n;
            nRxTx     <= nrxtx_n;
            transTrig <= trans_trig_n;
            sendDat   <= send_dat_n;
            copyEn    <= copy_en_n;
            cmdDone   <= cmd_done_n;
            cmdFailed <= cmd_failed_n;
        end
    end

    // Outputs are registered: each state's output values appear one cycle after entry.
    always_comb begin
        state_n      = state;
        byte_idx_n   = byte_idx;
        mismatch_n   = mismatch;
        prog_cnt_n   = prog_cnt;
        tx_cnt_n     = tx_cnt;
        nrxtx_n      = nRxTx;
        trans_trig_n = 1'b0;
        send_dat_n   = sendDat;
        copy_en_n    = 1'b0;
        cmd_done_n   = 1'b0;
        cmd_failed_n = 1'b0;

        case (state)
            ST_IDLE: begin
                nrxtx_n = DIR_RX;
                if (cmdRunTrig) begin
                    byte_idx_n = '0;
                    mismatch_n = 1'b0;
                    state_n    = ST_RX_TRIG;
                end
            end
            ST_RX_TRIG: begin
                nrxtx_n      = DIR_RX;
                trans_trig_n = 1'b1;
                state_n      = ST_RX_WAIT;
            end
            ST_RX_WAIT: begin
                if (done_rise) begin
                    mismatch_n = mismatch | (receiveDat != auth_byte(byte_idx, TA1, TA2, ES));
                    if (byte_idx == 2'd2) begin
                        state_n = ST_CHECK;
                    end else begin
                        byte_idx_n = byte_idx + 2'd1;
                        state_n    = ST_RX_TRIG;
                    end
                end
            end
            ST_CHECK: begin
                state_n = mismatch ? ST_FAIL : ST_COPY;
            end
            ST_COPY: begin
                copy_en_n  = 1'b1;
                prog_cnt_n = PW'(PROG_CYCLES);
                tx_cnt_n   = '0;
                state_n    = ST_PROG;
            end
            ST_PROG: begin
                if (prog_cnt <= PW'(1)) begin
                    prog_cnt_n = '0;
                    state_n    = ST_TX_TRIG;
                end else begin
                    prog_cnt_n = prog_cnt - PW'(1);
                end
            end
            ST_TX_TRIG: begin
                nrxtx_n      = DIR_TX;
                send_dat_n   = AA_PATTERN;
                trans_trig_n = 1'b1;
                state_n      = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (done_rise) begin
                    tx_cnt_n = tx_cnt_inc;
                    state_n  = (tx_cnt_inc >= TW'(AA_BYTES)) ? ST_DONE : ST_TX_TRIG;
                end
            end
            ST_DONE: begin
                cmd_done_n = 1'b1;
                state_n    = ST_IDLE;
            end
            ST_FAIL: begin
                cmd_failed_n = 1'b1;
                state_n      = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_virtual_ds2431_mem_copy_scratchpad.sv
// Bench for the Copy Scratchpad handler: a behavioural byte-transfer engine plus
// an event scoreboard checking pulse order, direction, data and latencies.
module tb_virtual_ds2431_mem_copy_scratchpad;
    import virtual_ds2431_pkg::*;

    localparam int PROG_CYCLES = 16;
    localparam int AA_BYTES    = 2;

    typedef enum int {EV_NONE, EV_RX, EV_TX, EV_COPY, EV_DONE, EV_FAIL} ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] TA1, TA2, ES;
    logic       cmdRunTrig;
    logic [7:0] receiveDat;
    logic       nRxTx;
    logic       transTrig;
    logic       ByteTransDone;
    logic [7:0] sendDat;
    logic       copyEn;
    logic       cmdDone;
    logic       cmdFailed;

    ev_t        exp_q[$];
    logic [7:0] rx_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int cmd_cyc = 0;
    int start_id = 0;
    int seen_id = 0;
    int copy_cyc = 0;
    bit tx_first = 1'b0;
    int glitch_req = 0;
    int glitch_seen = 0;
    int eng_cnt = 0;

    virtual_ds2431_mem_copy_scratchpad #(
        .PROG_CYCLES (PROG_CYCLES),
        .AA_BYTES    (AA_BYTES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .TA1           (TA1),
        .TA2           (TA2),
        .ES            (ES),
        .cmdRunTrig    (cmdRunTrig),
        .receiveDat    (receiveDat),
        .nRxTx         (nRxTx),
        .transTrig     (transTrig),
        .ByteTransDone (ByteTransDone),
        .sendDat       (sendDat),
        .copyEn        (copyEn),
        .cmdDone       (cmdDone),
        .cmdFailed     (cmdFailed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Transfer engine model: busy for 3 cycles after each trigger; can also
    // produce a spurious low/high glitch on request.
    always @(negedge clk) begin
        if (rst) begin
            eng_cnt       = 0;
            ByteTransDone = 1'b1;
            receiveDat    = 8'h00;
        end else if (transTrig) begin
            if (!nRxTx) begin
                if (rx_q.size() > 0) receiveDat = rx_q.pop_front();
                else                 receiveDat = 8'h00;
            end
            ByteTransDone = 1'b0;
            eng_cnt       = 3;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) ByteTransDone = 1'b1;
        end else if (glitch_seen != glitch_req) begin
            glitch_seen++;
            ByteTransDone = 1'b0;
            eng_cnt       = 2;
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        ev_t ev;
        ev_t e;
        int  npulse;
        if (rst) begin
            tx_first = 1'b0;
        end else begin
            npulse = int'(transTrig) + int'(copyEn) + int'(cmdDone) + int'(cmdFailed);
            if (npulse > 1) check("pulse_overlap", 32'(npulse), 32'd1);
            ev = EV_NONE;
            if (transTrig)      ev = nRxTx ? EV_TX : EV_RX;
            else if (copyEn)    ev = EV_COPY;
            else if (cmdDone)   ev = EV_DONE;
            else if (cmdFailed) ev = EV_FAIL;
            if (ev != EV_NONE) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(ev), 32'(EV_NONE));
                end else begin
                    e = exp_q.pop_front();
                    check("event", 32'(ev), 32'(e));
                end
                if (ev == EV_TX) check("sendDat", 32'(sendDat), 32'(AA_PATTERN));
                if (ev == EV_RX && seen_id != start_id) begin
                    check("first_trig_latency", 32'(cyc - cmd_cyc), 32'd2);
                    seen_id = start_id;
                end
                if (ev == EV_COPY) begin
                    copy_cyc = cyc;
                    tx_first = 1'b1;
                end
                if (ev == EV_TX && tx_first) begin
                    check("prog_latency", 32'(cyc - copy_cyc), 32'(PROG_CYCLES + 1));
                    tx_first = 1'b0;
                end
            end
        end
    end

    task automatic start_cmd();
        @(negedge clk);
        cmdRunTrig = 1'b1;
        cmd_cyc    = cyc;
        start_id++;
        @(negedge clk);
        cmdRunTrig = 1'b0;
    endtask

    task automatic push_expect(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input bit ok);
        rx_q.push_back(b0);
        rx_q.push_back(b1);
        rx_q.push_back(b2);
        repeat (3) exp_q.push_back(EV_RX);
        if (ok) begin
            exp_q.push_back(EV_COPY);
            repeat (AA_BYTES) exp_q.push_back(EV_TX);
            exp_q.push_back(EV_DONE);
        end else begin
            exp_q.push_back(EV_FAIL);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("events_pending", 32'(exp_q.size()), 32'd0);
        check("rx_bytes_left", 32'(rx_q.size()), 32'd0);
        exp_q.delete();
        rx_q.delete();
        repeat (6) @(negedge clk);
    endtask

    task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input bit ok, input bit retrig);
        push_expect(b0, b1, b2, ok);
        start_cmd();
        if (retrig) begin
            repeat (2) @(negedge clk);
            cmdRunTrig = 1'b1;
            @(negedge clk);
            cmdRunTrig = 1'b0;
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst        = 1'b1;
        cmdRunTrig = 1'b0;
        TA1 = 8'h20; TA2 = 8'h00; ES = 8'h07;
        repeat (3) @(negedge clk);
        check("rst_nRxTx", 32'(nRxTx), 32'd0);
        check("rst_transTrig", 32'(transTrig), 32'd0);
        check("rst_sendDat", 32'(sendDat), 32'hAA);
        check("rst_copyEn", 32'(copyEn), 32'd0);
        check("rst_cmdDone", 32'(cmdDone), 32'd0);
        check("rst_cmdFailed", 32'(cmdFailed), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Matching authorization
        run_cmd(8'h20, 8'h00, 8'h07, 1'b1, 1'b0);

        // ES mismatch, followed by spurious done edges that must be ignored
        run_cmd(8'h20, 8'h00, 8'h08, 1'b0, 1'b0);
        glitch_req++;
        repeat (8) @(negedge clk);
        check("idle_nRxTx_after_fail", 32'(nRxTx), 32'd0);

        // Nonzero TA2
        TA2 = 8'h20;
        run_cmd(8'h20, 8'h20, 8'h07, 1'b1, 1'b0);

        // TA1 mismatch on the first byte: still receives all three
        TA2 = 8'h00;
        run_cmd(8'h21, 8'h00, 8'h07, 1'b0, 1'b0);

        // Reset during PROG
        push_expect(8'h20, 8'h00, 8'h07, 1'b1);
        start_cmd();
        k = 0;
        while (copyEn !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("copy_seen_before_reset", 32'(copyEn), 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_nRxTx", 32'(nRxTx), 32'd0);
        check("midrst_transTrig", 32'(transTrig), 32'd0);
        check("midrst_sendDat", 32'(sendDat), 32'hAA);
        check("midrst_copyEn", 32'(copyEn), 32'd0);
        check("midrst_cmdDone", 32'(cmdDone), 32'd0);
        check("midrst_cmdFailed", 32'(cmdFailed), 32'd0);
        exp_q.delete();
        rx_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_cmd(8'h20, 8'h00, 8'h07, 1'b1, 1'b0);

        // cmdRunTrig re-pulsed while waiting for a byte
        run_cmd(8'h20, 8'h00, 8'h07, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/virtual_ds2431_mem_copy_scratchpad.md
Name: virtual_ds2431_mem_copy_scratchpad

Overview:
- Command handler for the DS2431 Copy Scratchpad function (ROM/memory command 0x55) in the virtual 1-Wire EEPROM.
- Started by the memory-command dispatcher after the command byte has been decoded.
- Receives the 3-byte authorization (TA1, TA2, E/S) through the shared byte-transfer engine and compares it with the stored scratchpad address/status.
- On a match it requests the copy, waits the programming time, then sends the 0xAA success pattern; on a mismatch it aborts.

Parameters:
- PROG_CYCLES, default 16: clk cycles between the copy request and the first 0xAA byte (emulated tPROG).
- AA_BYTES, default 2: number of 0xAA bytes transmitted after programming.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- TA1  in  8  stored target address, low byte.
- TA2  in  8  stored target address, high byte.
- ES  in  8  stored ending-offset/status byte.
- cmdRunTrig  in  1  start request; sampled high in IDLE.
- receiveDat  in  8  byte last received by the transfer engine; valid when ByteTransDone rises after a receive.
- nRxTx  out  1  direction for the requested transfer: 0 = receive, 1 = transmit.
- transTrig  out  1  one-cycle pulse starting one byte transfer.
- ByteTransDone  in  1  transfer engine idle/done level: low while busy, high when idle.
- sendDat  out  8  byte to transmit; 0xAA whenever nRxTx=1.
- copyEn  out  1  one-cycle pulse: copy scratchpad to memory at {TA2,TA1}.
- cmdDone  out  1  one-cycle pulse: command completed successfully.
- cmdFailed  out  1  one-cycle pulse: authorization mismatch.

Behaviour:
- Reset values: nRxTx=0, transTrig=0, sendDat=0xAA, copyEn=0, cmdDone=0, cmdFailed=0. State is IDLE, counters and the capture register are 0.
- Reset asserted mid-command aborts immediately to IDLE with no done or failed pulse.
- Completion of a transfer is the rising edge of ByteTransDone, detected with a one-cycle delayed copy. Edges outside the WAIT states are ignored.
- State machine:
  - IDLE: when cmdRunTrig=1, clear byte index and the mismatch flag, then go to RX_TRIG. cmdRunTrig is ignored in every other state.
  - RX_TRIG: nRxTx=0, pulse transTrig, go to RX_WAIT.
  - RX_WAIT: on the ByteTransDone rising edge, compare receiveDat with the expected byte and OR any difference into the mismatch flag. Expected byte is TA1 for index 0, TA2 for index 1, ES for index 2. Index 0 or 1 returns to RX_TRIG with index+1; index 2 goes to CHECK.
  - CHECK: mismatch flag set goes to FAIL; otherwise go to COPY.
  - COPY: pulse copyEn, load the programming counter, go to PROG.
  - PROG: count PROG_CYCLES clocks, then go to TX_TRIG.
  - TX_TRIG: nRxTx=1, sendDat=0xAA, pulse transTrig, go to TX_WAIT.
  - TX_WAIT: on the ByteTransDone rising edge, return to TX_TRIG if fewer than AA_BYTES bytes have been sent; otherwise go to DONE.
  - DONE: pulse cmdDone, go to IDLE.
  - FAIL: pulse cmdFailed, go to IDLE. No further transfer is triggered.
- Comparison uses exact 8-bit equality on all three bytes. No other validation is done in this block.
- nRxTx holds its last value between transfers and returns to 0 in IDLE.
- Latency:
  - cmdRunTrig to first transTrig: 2 cycles.
  - Last rx done edge to copyEn: 2 cycles.
  - copyEn to first 0xAA transTrig: PROG_CYCLES+1 cycles.
- cmdDone and cmdFailed are mutually exclusive, and exactly one of them fires per completed command.

Decomposition:
- Shared package virtual_ds2431_pkg holds:
  - the command code constant CMD_COPY_SCRATCHPAD = 8'h55;
  - the success pattern AA_PATTERN = 8'hAA;
  - the direction constants DIR_RX=0 and DIR_TX=1;
  - the state enum.
- One natural sub-module: ds2431_done_edge, the rising-edge detector on ByteTransDone, reused by other command handlers.

Test Plan:
- Match: TA1=0x20, TA2=0x00, ES=0x07, pulse cmdRunTrig; bytes 0x20, 0x00, 0x07 -> three rx transTrig pulses with nRxTx=0, then one copyEn, then after PROG_CYCLES two tx transTrig pulses with nRxTx=1 and sendDat=0xAA, then one cmdDone pulse; cmdFailed stays 0.
- ES mismatch: stored ES=0x07, bytes 0x20, 0x00, 0x08 -> cmdFailed pulse after the third byte; no copyEn, no tx transTrig, no cmdDone; further ByteTransDone edges are ignored.
- Nonzero TA2: TA1=0x20, TA2=0x20, ES=0x07, bytes 0x20, 0x20, 0x07 -> success sequence identical to the first scenario.
- TA1 mismatch on the first byte: bytes 0x21, 0x00, 0x07 -> all three bytes are still received, then cmdFailed.
- Reset mid-PROG: assert rst during PROG -> outputs return to reset values immediately, no cmdDone; a fresh matching command afterwards succeeds.
- cmdRunTrig pulsed again while in RX_WAIT -> ignored; the sequence completes normally with a single cmdDone.
